// File: rtl/pam4_slicer_checker.sv
// PAM4 receive slicer and symbol checker: slices noisy samples against a FIFO of transmitted symbols.
// Define GRAY_MAP_EN to use Gray-coded symbol indices (levels 0,1,2,3 -> 0,1,3,2).
module pam4_slicer_checker #(
  parameter int LEVEL_A     = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_SYMBOLS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic signed [7:0] sample_in,
  input  logic              sample_in_valid,
  input  logic [1:0]        ref_sym_in,
  input  logic              ref_sym_valid,
  output logic [1:0]        sym_out,
  output logic              sym_out_valid,
  output logic              sym_err,
  output logic [CNT_W-1:0]  sym_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              done,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic signed [8:0] THR_POS = 9'(2 * LEVEL_A);
  localparam logic signed [8:0] THR_NEG = -THR_POS;
  // A target beyond the counter range is clamped to the saturation value.
  localparam logic [CNT_W-1:0] NUM_C =
    (longint'(NUM_SYMBOLS) >= (longint'(1) << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(NUM_SYMBOLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   fifo_cnt;

  logic               fifo_empty;
  logic               fifo_full;
  logic               run_active;
  logic               pop;
  logic               push_ok;
  logic               push_drop;
  logic signed [8:0]  sample_ext;
  logic [1:0]         level;
  logic [1:0]         sym_sliced;
  logic               mismatch;
  logic [CNT_W-1:0]   sym_count_nxt;
  logic [CNT_W-1:0]   err_count_nxt;

  function automatic logic [1:0] slice_level(input logic signed [8:0] s);
    if (s < THR_NEG)      return 2'd0;
    else if (s < 9'sd0)   return 2'd1;
    else if (s < THR_POS) return 2'd2;
    else                  return 2'd3;
  endfunction

  assign sample_ext = {sample_in[7], sample_in};
  assign level      = slice_level(sample_ext);

`ifdef GRAY_MAP_EN
  assign sym_sliced = level ^ {1'b0, level[1]};
`else
  assign sym_sliced = level;
`endif

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == OCC_FULL);
  assign run_active = (state == S_RUN) && en;
  // A pop frees a slot this cycle, so a push into a full FIFO alongside a pop is accepted.
  assign pop        = run_active && sample_in_valid && !fifo_empty;
  assign push_ok    = run_active && ref_sym_valid && (!fifo_full || pop);
  assign push_drop  = run_active && ref_sym_valid && fifo_full && !pop;
  assign mismatch   = (sym_sliced != mem[rd_ptr]);

  assign sym_count_nxt = (sym_count == {CNT_W{1'b1}}) ? sym_count : sym_count + 1'b1;
  assign err_count_nxt = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + 1'b1;

  // Reference storage carries no reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ref_sym_in;
  end

  // Run control, FIFO bookkeeping and the registered compare result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      sym_out       <= 2'd0;
      sym_out_valid <= 1'b0;
      sym_err       <= 1'b0;
      sym_count     <= '0;
      err_count     <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      sym_out_valid <= 1'b0;
      sym_err       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          fifo_cnt <= '0;
          if (en) begin
            state     <= S_RUN;
            sym_count <= '0;
            err_count <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end

        S_RUN: begin
          if (!en) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
          end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
              2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
              2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
              default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_drop) overflow <= 1'b1;

            if (sample_in_valid) begin
              sym_out       <= sym_sliced;
              sym_out_valid <= 1'b1;
              if (pop) begin
                sym_err   <= mismatch;
                sym_count <= sym_count_nxt;
                if (mismatch) err_count <= err_count_nxt;
                if (sym_count_nxt == NUM_C) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end else begin
                underflow <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          fifo_cnt <= '0;
          if (!en) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pam4_slicer_checker.sv
// Directed self-checking bench for pam4_slicer_checker: vector table plus multi-cycle FIFO/control sequences.
module tb_pam4_slicer_checker;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              en;
  logic signed [7:0] sample_in;
  logic              sample_in_valid;
  logic [1:0]        ref_sym_in;
  logic              ref_sym_valid;

  logic [1:0]        sym_out;
  logic              sym_out_valid;
  logic              sym_err;
  logic [CNT_W-1:0]  sym_count;
  logic [CNT_W-1:0]  err_count;
  logic              done;
  logic              overflow;
  logic              underflow;

  logic [1:0]        d4_sym_out;
  logic              d4_sym_out_valid;
  logic              d4_sym_err;
  logic [CNT_W-1:0]  d4_sym_count;
  logic [CNT_W-1:0]  d4_err_count;
  logic              d4_done;
  logic              d4_overflow;
  logic              d4_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pam4_slicer_checker #(
    .LEVEL_A(32), .FIFO_DEPTH(8), .NUM_SYMBOLS(1024), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .ref_sym_in(ref_sym_in), .ref_sym_valid(ref_sym_valid),
    .sym_out(sym_out), .sym_out_valid(sym_out_valid), .sym_err(sym_err),
    .sym_count(sym_count), .err_count(err_count), .done(done),
    .overflow(overflow), .underflow(underflow)
  );

  // Short run used to observe completion; shares all stimulus with the main instance.
  pam4_slicer_checker #(
    .LEVEL_A(32), .FIFO_DEPTH(8), .NUM_SYMBOLS(4), .CNT_W(CNT_W)
  ) dut4 (
    .clk(clk), .rstn(rstn), .en(en),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .ref_sym_in(ref_sym_in), .ref_sym_valid(ref_sym_valid),
    .sym_out(d4_sym_out), .sym_out_valid(d4_sym_out_valid), .sym_err(d4_sym_err),
    .sym_count(d4_sym_count), .err_count(d4_err_count), .done(d4_done),
    .overflow(d4_overflow), .underflow(d4_underflow)
  );

  typedef struct {
    int sample;
    int ref_lvl;
    int exp_lvl;
    int exp_err;
  } vec_t;

  vec_t vecs [14];

  function automatic int gmap(input int lvl);
`ifdef GRAY_MAP_EN
    return lvl ^ (lvl >> 1);
`else
    return lvl;
`endif
  endfunction

  function automatic int nominal(input int lvl);
    case (lvl)
      0:       return -96;
      1:       return -32;
      2:       return 32;
      default: return 96;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; on return the outputs reflect that clock edge.
  task automatic applyStimulus(input int s_valid, input int sample, input int r_valid, input int ref_idx);
    sample_in       = 8'(sample);
    sample_in_valid = 1'(s_valid);
    ref_sym_in      = 2'(ref_idx);
    ref_sym_valid   = 1'(r_valid);
    tick();
    sample_in_valid = 1'b0;
    ref_sym_valid   = 1'b0;
  endtask

  task automatic restart_run();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
  endtask

  task automatic run_group(input int first, input int n);
    for (int i = first; i < first + n; i++) applyStimulus(0, 0, 1, gmap(vecs[i].ref_lvl));
    tick();
    tick();
    for (int i = first; i < first + n; i++) begin
      applyStimulus(1, vecs[i].sample, 0, 0);
      checkOutput($sformatf("vec%0d_valid", i), int'(sym_out_valid), 1);
      checkOutput($sformatf("vec%0d_sym", i), int'(sym_out), gmap(vecs[i].exp_lvl));
      checkOutput($sformatf("vec%0d_err", i), int'(sym_err), vecs[i].exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain_lvls [8];

    vecs[0]  = '{-96, 0, 0, 0};
    vecs[1]  = '{-32, 1, 1, 0};
    vecs[2]  = '{32, 2, 2, 0};
    vecs[3]  = '{96, 3, 3, 0};
    vecs[4]  = '{-65, 0, 0, 0};
    vecs[5]  = '{-64, 1, 1, 0};
    vecs[6]  = '{0, 2, 2, 0};
    vecs[7]  = '{64, 3, 3, 0};
    vecs[8]  = '{-128, 0, 0, 0};
    vecs[9]  = '{127, 3, 3, 0};
    vecs[10] = '{32, 2, 2, 0};
    vecs[11] = '{-1, 2, 1, 1};
    vecs[12] = '{63, 2, 2, 0};
    vecs[13] = '{64, 2, 3, 1};
    drain_lvls = '{1, 2, 3, 0, 1, 2, 3, 1};

    rstn = 1'b0; en = 1'b0;
    sample_in = '0; sample_in_valid = 1'b0; ref_sym_in = '0; ref_sym_valid = 1'b0;
    tick(); tick();
    checkOutput("rst_sym_out", int'(sym_out), 0);
    checkOutput("rst_valid", int'(sym_out_valid), 0);
    checkOutput("rst_err", int'(sym_err), 0);
    checkOutput("rst_sym_count", int'(sym_count), 0);
    checkOutput("rst_err_count", int'(err_count), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_underflow", int'(underflow), 0);
    rstn = 1'b1;
    tick();
    applyStimulus(1, 96, 0, 0);
    checkOutput("idle_valid_ignored", int'(sym_out_valid), 0);

    en = 1'b1;
    tick();
    $display("[TB] nominal levels and threshold edges");
    run_group(0, 4);
    checkOutput("g1_sym_count", int'(sym_count), 4);
    checkOutput("g1_err_count", int'(err_count), 0);
    run_group(4, 6);
    checkOutput("g2_sym_count", int'(sym_count), 10);
    checkOutput("g2_err_count", int'(err_count), 0);

    $display("[TB] errors and run completion");
    restart_run();
    for (int i = 10; i < 14; i++) applyStimulus(0, 0, 1, gmap(vecs[i].ref_lvl));
    tick();
    tick();
    for (int i = 10; i < 14; i++) begin
      applyStimulus(1, vecs[i].sample, 0, 0);
      checkOutput($sformatf("vec%0d_sym", i), int'(sym_out), gmap(vecs[i].exp_lvl));
      checkOutput($sformatf("vec%0d_err", i), int'(sym_err), vecs[i].exp_err);
      checkOutput($sformatf("d4_done_at%0d", i), int'(d4_done), (i == 13) ? 1 : 0);
      checkOutput($sformatf("d4_valid_at%0d", i), int'(d4_sym_out_valid), 1);
    end
    checkOutput("g3_sym_count", int'(sym_count), 4);
    checkOutput("g3_err_count", int'(err_count), 2);
    checkOutput("d4_sym_count", int'(d4_sym_count), 4);
    checkOutput("d4_err_count", int'(d4_err_count), 2);

    applyStimulus(0, 0, 1, gmap(0));
    applyStimulus(1, -96, 0, 0);
    checkOutput("d4_frozen_valid", int'(d4_sym_out_valid), 0);
    checkOutput("d4_frozen_sym_count", int'(d4_sym_count), 4);
    checkOutput("d4_frozen_err_count", int'(d4_err_count), 2);
    checkOutput("main_after_done_count", int'(sym_count), 5);

    $display("[TB] enable drop mid-run");
    applyStimulus(0, 0, 1, gmap(1));
    en = 1'b0;
    tick();
    checkOutput("en_drop_count_kept", int'(sym_count), 5);
    checkOutput("en_drop_done", int'(done), 0);
    checkOutput("d4_done_held_idle", int'(d4_done), 1);
    en = 1'b1;
    tick();
    checkOutput("restart_count_clr", int'(sym_count), 0);
    checkOutput("restart_err_clr", int'(err_count), 0);
    checkOutput("d4_restart_done_clr", int'(d4_done), 0);
    applyStimulus(1, -32, 0, 0);
    checkOutput("flushed_valid", int'(sym_out_valid), 1);
    checkOutput("flushed_underflow", int'(underflow), 1);
    checkOutput("flushed_count", int'(sym_count), 0);

    $display("[TB] fifo full, overflow, drain and underflow");
    restart_run();
    checkOutput("fifo_underflow_clr", int'(underflow), 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, gmap(i % 4));
    checkOutput("full_no_overflow", int'(overflow), 0);
    applyStimulus(1, nominal(0), 1, gmap(1));
    checkOutput("full_pushpop_sym", int'(sym_out), gmap(0));
    checkOutput("full_pushpop_err", int'(sym_err), 0);
    checkOutput("full_pushpop_overflow", int'(overflow), 0);
    applyStimulus(0, 0, 1, gmap(2));
    checkOutput("drop_overflow", int'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, nominal(drain_lvls[i]), 0, 0);
      checkOutput($sformatf("drain%0d_sym", i), int'(sym_out), gmap(drain_lvls[i]));
      checkOutput($sformatf("drain%0d_err", i), int'(sym_err), 0);
    end
    checkOutput("drain_count", int'(sym_count), 9);
    checkOutput("drain_err_count", int'(err_count), 0);
    checkOutput("pre_empty_underflow", int'(underflow), 0);
    applyStimulus(1, 96, 0, 0);
    checkOutput("empty_valid", int'(sym_out_valid), 1);
    checkOutput("empty_sym", int'(sym_out), gmap(3));
    checkOutput("empty_err", int'(sym_err), 0);
    checkOutput("empty_underflow", int'(underflow), 1);
    checkOutput("empty_count", int'(sym_count), 9);
    tick();
    checkOutput("hold_valid", int'(sym_out_valid), 0);
    checkOutput("hold_sym", int'(sym_out), gmap(3));

    $display("[TB] asynchronous reset mid-run");
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("arst_sym_out", int'(sym_out), 0);
    checkOutput("arst_sym_count", int'(sym_count), 0);
    checkOutput("arst_overflow", int'(overflow), 0);
    checkOutput("arst_underflow", int'(underflow), 0);
    checkOutput("arst_done", int'(done), 0);
    tick();
    rstn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
